// File: rtl/hilo_muldiv_if.sv
// EX-stage request/response bundle between the pipeline and the HI/LO unit.
// The pipeline drives the request side; the unit returns stall, read data and HI/LO.
interface hilo_muldiv_if;
  logic        valid;
  logic        flush;
  logic [7:0]  alucontrol;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall;
  logic [31:0] hilo_rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output valid, flush, alucontrol, a, b,
    input  stall, hilo_rdata, hi, lo
  );

  modport slave (
    input  valid, flush, alucontrol, a, b,
    output stall, hilo_rdata, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv.sv
// HI/LO unit: single-cycle MULT/MULTU and MTHI/MTLO, 32-iteration restoring
// DIV/DIVU that stalls the pipeline, and MFHI/MFLO read-back into the EX mux.
module hilo_muldiv (
  input  logic         clk,
  input  logic         resetn,
  hilo_muldiv_if.slave bus
);

  // Operation codes as assigned by the ALU decoder.
  localparam logic [7:0] EXE_MFHI_OP  = 8'h10;
  localparam logic [7:0] EXE_MTHI_OP  = 8'h11;
  localparam logic [7:0] EXE_MFLO_OP  = 8'h12;
  localparam logic [7:0] EXE_MTLO_OP  = 8'h13;
  localparam logic [7:0] EXE_MULT_OP  = 8'h18;
  localparam logic [7:0] EXE_MULTU_OP = 8'h19;
  localparam logic [7:0] EXE_DIV_OP   = 8'h1A;
  localparam logic [7:0] EXE_DIVU_OP  = 8'h1B;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dq_q, dq_d;          // dividend shifts out the top, quotient fills the bottom
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] rem_q, rem_d;
  logic        q_sign_q, q_sign_d;
  logic        r_sign_q, r_sign_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        stall;

  logic        issue;
  logic        is_div;
  logic        signed_div;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [32:0] partial;
  logic [32:0] trial;

  assign issue      = bus.valid && !bus.flush && (state_q == IDLE);
  assign is_div     = (bus.alucontrol == EXE_DIV_OP) || (bus.alucontrol == EXE_DIVU_OP);
  assign signed_div = (bus.alucontrol == EXE_DIV_OP);
  assign a_mag      = (signed_div && bus.a[31]) ? -bus.a : bus.a;
  assign b_mag      = (signed_div && bus.b[31]) ? -bus.b : bus.b;
  assign prod_s     = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
  assign prod_u     = {32'd0, bus.a} * {32'd0, bus.b};
  assign partial    = {rem_q, dq_q[31]};
  assign trial      = partial - {1'b0, divisor_q};

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    dq_d      = dq_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    q_sign_d  = q_sign_q;
    r_sign_d  = r_sign_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stall     = 1'b0;

    case (state_q)
      IDLE: begin
        if (issue) begin
          case (bus.alucontrol)
            EXE_MULT_OP:  {hi_d, lo_d} = prod_s;
            EXE_MULTU_OP: {hi_d, lo_d} = prod_u;
            EXE_MTHI_OP:  hi_d = bus.a;
            EXE_MTLO_OP:  lo_d = bus.a;
            EXE_DIV_OP, EXE_DIVU_OP: begin
              // A zero divisor leaves the unit idle and HI/LO untouched.
              if (bus.b != 32'd0) begin
                stall     = 1'b1;
                dq_d      = a_mag;
                divisor_d = b_mag;
                rem_d     = 32'd0;
                cnt_d     = 5'd0;
                q_sign_d  = signed_div && (bus.a[31] ^ bus.b[31]);
                r_sign_d  = signed_div && bus.a[31];
                state_d   = DIV;
              end
            end
            default: ;
          endcase
        end
      end
      DIV: begin
        stall = 1'b1;
        // A borrow out of bit 32 means the trial subtraction failed: restore.
        rem_d = trial[32] ? partial[31:0] : trial[31:0];
        dq_d  = {dq_q[30:0], ~trial[32]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DONE;
      end
      DONE: begin
        lo_d    = q_sign_q ? -dq_q  : dq_q;
        hi_d    = r_sign_q ? -rem_q : rem_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      dq_q      <= 32'd0;
      divisor_q <= 32'd0;
      rem_q     <= 32'd0;
      q_sign_q  <= 1'b0;
      r_sign_q  <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dq_q      <= dq_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      q_sign_q  <= q_sign_d;
      r_sign_q  <= r_sign_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.stall      = stall;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.hilo_rdata = (bus.alucontrol == EXE_MFHI_OP) ? hi_q :
                          (bus.alucontrol == EXE_MFLO_OP) ? lo_q : 32'd0;

endmodule
